reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 108 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file writeback arbiter, round-robin or fixed priority
// Define WB_FIXED_PRIO_EN for fixed priority (index 0 highest); default build is round-robin.
module reg_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [5*NREQ-1:0]    req_addr_i,
    input  logic [32*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic                 stall_in_i,
    output logic                 wr_en_o,
    output logic [4:0]           wr_addr_o,
    output logic [31:0]          wr_data_o,
    output logic [CNT_W-1:0]     conflict_cnt_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] idx;
    logic [4:0]       grant_addr;
    logic [31:0]      grant_data;
    logic             contended;

    // Search starts at ptr_q; the fixed-priority build simply pins ptr_q to 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        if (stall_in_i || !rst_n_i) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = req_addr_i[5*grant_idx +: 5];
    assign grant_data = req_data_i[32*grant_idx +: 32];
    assign contended  = !stall_in_i && ($countones(req_valid_i) >= 2);

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
`ifdef WB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (grant_vld) begin
            ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
`endif
        // x0 writes are accepted but dropped; address/data registers keep their old value.
        if (grant_vld && grant_addr != 5'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = grant_addr;
            wr_data_d = grant_data;
        end
        if (contended && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [5*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                stall;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [31:0]         wr_data;
    logic [CNT_W-1:0]    cnt;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .stall_in_i     (stall),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .conflict_cnt_o (cnt)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    int          grant_log[$];
    bit          pv[NREQ];
    logic [4:0]  pa[NREQ];
    logic [31:0] pd[NREQ];
    int          m_ptr;
    int          m_cnt;
    logic [4:0]  m_last_a;
    logic [31:0] m_last_d;
    wr_t         mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pv[i];
            req_addr[5*i +: 5]  = pa[i];
            req_data[32*i +: 32] = pd[i];
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_cnt    = 0;
        m_last_a = '0;
        m_last_d = '0;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    endtask

    // One cycle: present pending requests, predict the grant from the round-robin rule.
    task automatic step(input bit st);
        int nv;
        int g;
        int id;
        logic [NREQ-1:0] er;
        @(negedge clk);
        stall = st;
        drive();
        #1;
        nv = 0;
        g  = -1;
        for (int i = 0; i < NREQ; i++) nv += pv[i] ? 1 : 0;
        if (!st) begin
            for (int k = 0; k < NREQ; k++) begin
                id = (m_ptr + k) % NREQ;
                if (g < 0 && pv[id]) g = id;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        if (g >= 0) begin
            if (pa[g] != 0) exp_q.push_back({pa[g], pd[g]});
            pv[g] = 1'b0;
            grant_log.push_back(g);
`ifdef WB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
        if (!st && nv >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic arm(input int i, input logic [4:0] a, input logic [31:0] d);
        pv[i] = 1'b1;
        pa[i] = a;
        pd[i] = d;
    endtask

    // Monitor: compares registered outputs against the expected-write queue.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("wr_en_in_reset", wr_en, 1'b0);
            check("cnt_in_reset", cnt, '0);
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual addr %0h required no write", wr_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", wr_addr, mon_e.a);
                    check("wr_data", wr_data, mon_e.d);
                    m_last_a = mon_e.a;
                    m_last_d = mon_e.d;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_write: actual wr_en 0 required write to %0h", exp_q[0].a);
                    exp_q.delete();
                end
                check("wr_addr_hold", wr_addr, m_last_a);
                check("wr_data_hold", wr_data, m_last_d);
            end
            check("conflict_cnt", cnt, m_cnt);
        end
    end

    int base;
    int exp_seq[5];
    int exp_g;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        model_reset();
        drive();
        req_valid = '1;
        #1;
        check("reset_ready", req_ready, '0);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_wr_addr", wr_addr, '0);
        check("reset_wr_data", wr_data, '0);
        check("reset_cnt", cnt, '0);
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then verify pointer moved past it.
        arm(1, 5'd5, 32'hDEADBEEF);
        step(1'b0);
        check("single_req_ready", req_ready, 3'b010);
        @(posedge clk); #2;
        check("single_wr_en", wr_en, 1'b1);
        check("single_wr_addr", wr_addr, 5'd5);
        check("single_wr_data", wr_data, 32'hDEADBEEF);
        arm(0, 5'd9, 32'h9);
        arm(2, 5'd10, 32'hA);
        step(1'b0);
`ifdef WB_FIXED_PRIO_EN
        exp_g = 0;
`else
        exp_g = 2;
`endif
        check("ptr_after_req1", grant_log[grant_log.size()-1], exp_g);
        step(1'b0);
        step(1'b0);

        // Three-way contention from reset.
        do_reset();
        arm(0, 5'd1, 32'h11);
        arm(1, 5'd2, 32'h22);
        arm(2, 5'd3, 32'h33);
        base = grant_log.size();
        repeat (3) step(1'b0);
        @(posedge clk); #2;
        check("rr_grant0", grant_log[base], 0);
        check("rr_grant1", grant_log[base+1], 1);
        check("rr_grant2", grant_log[base+2], 2);
        check("rr_cnt", cnt, 2);

        // x0 write accepted but dropped.
        arm(2, 5'd0, 32'h1234);
        step(1'b0);
        check("x0_ready", req_ready, 3'b100);
        @(posedge clk); #2;
        check("x0_wr_en", wr_en, 1'b0);
        check("x0_wr_addr", wr_addr, 5'd3);

        // Stall blocks everything, then req0 goes first.
        arm(0, 5'd4, 32'h44);
        arm(1, 5'd6, 32'h66);
        repeat (4) step(1'b1);
        check("stall_cnt", cnt, 2);
        step(1'b0);
        check("after_stall_grant", grant_log[grant_log.size()-1], 0);
        step(1'b0);

        // Counter saturation with CNT_W=2.
        do_reset();
        exp_seq = '{1, 2, 3, 3, 3};
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < NREQ; i++) if (!pv[i]) arm(i, 5'(8 + i), 32'(j * 16 + i));
            step(1'b0);
            @(posedge clk); #2;
            check("sat_cnt", cnt, exp_seq[j]);
        end
        repeat (3) step(1'b0);

        // Reset between a transfer and the next edge.
        do_reset();
        arm(0, 5'd7, 32'h77);
        step(1'b0);
        @(posedge clk); #2;
        check("pre_rst_wr_en", wr_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        req_valid = '1;
        #1;
        check("async_rst_wr_en", wr_en, 1'b0);
        check("async_rst_ready", req_ready, '0);
        check("async_rst_cnt", cnt, '0);
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        arm(0, 5'd12, 32'hC);
        arm(2, 5'd13, 32'hD);
        step(1'b0);
        check("post_rst_grant", grant_log[grant_log.size()-1], 0);
        step(1'b0);

        // Randomized traffic with small address space to force x0 and same-address writes.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1)
                    arm(i, 5'($urandom_range(0, 7)), $urandom);
            end
            step($urandom_range(0, 3) == 0);
        end
        for (int c = 0; c < 20; c++) begin
            if (pv[0] || pv[1] || pv[2]) step(1'b0);
        end
        step(1'b0);
        step(1'b0);
        check("drain_pending", {pv[0], pv[1], pv[2]}, 3'b000);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
